// File: rtl/mdr_sequencer.sv
// mdr_sequencer: control FSM for the multiply/divide/sqrt unit: operand loading, iteration counting, error codes.
module mdr_sequencer #(
  parameter int DW      = 16,
  parameter int ITER_MD = DW,
  parameter int ITER_SQ = DW / 2,
  parameter int CW      = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    op,
  input  logic          start,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          dp_ovf,
  input  logic          abort,
  input  logic          res_ack,
  output logic          ready,
  output logic          load_x,
  output logic          load_y,
  output logic          x_en,
  output logic          y_en,
  output logic [1:0]    op_q,
  output logic          iter_en,
  output logic          iter_first,
  output logic          iter_last,
  output logic [CW-1:0] iter_idx,
  output logic          shift,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);
  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, PROC, DONE, ERR} state_t;
  localparam logic [1:0] MULT = 2'b00, DIV = 2'b01, SQRT = 2'b10, ILL = 2'b11;
  localparam logic [1:0] E_NONE = 2'b00, E_DIV0 = 2'b01, E_SQNEG = 2'b10, E_OVF = 2'b11;
  state_t        state_q, state_d;
  logic [1:0]    op_d, err_q, err_d;
  logic [CW-1:0] iter_q, iter_d, last_idx;
  logic          ld_q, ld_ok;
  // A held load level must not fill both operands, so only its rising edge counts.
  assign ld_ok    = load & ~ld_q & ~start & ~abort;
  assign last_idx = (op_q == SQRT) ? CW'(ITER_SQ - 1) : CW'(ITER_MD - 1);
  // State, latched op, error code, iteration counter and load history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= MULT;
      err_q   <= E_NONE;
      iter_q  <= '0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
      ld_q    <= load;
    end
  end
  // Transitions; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        state_d = (op == ILL) ? ERR : LOAD_X;
        err_d   = (op == ILL) ? E_OVF : E_NONE;
      end
      LOAD_X: if (x_en) begin
        state_d = (op_q != SQRT) ? LOAD_Y : data_in[DW-1] ? ERR : PROC;
        err_d   = (op_q == SQRT && data_in[DW-1]) ? E_SQNEG : E_NONE;
      end
      LOAD_Y: if (y_en) begin
        state_d = (op_q == DIV && data_in == '0) ? ERR : PROC;
        err_d   = (op_q == DIV && data_in == '0) ? E_DIV0 : E_NONE;
      end
      PROC: if (iter_last) begin
        state_d = (op_q == MULT && dp_ovf) ? ERR : DONE;
        err_d   = (op_q == MULT && dp_ovf) ? E_OVF : E_NONE;
      end
      DONE: if (res_ack) begin
        op_d    = start ? op : op_q;
        state_d = !start ? IDLE : (op == ILL) ? ERR : LOAD_X;
        err_d   = (start && op == ILL) ? E_OVF : E_NONE;
      end
      ERR: if (res_ack) begin
        state_d = IDLE;
        err_d   = E_NONE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      op_d    = op_q;
      err_d   = E_NONE;
    end
    iter_d = (state_q == PROC && state_d == PROC) ? iter_q + CW'(1) : '0;
  end
  // Moore decode of state/counter; operand strobes follow the load edge directly.
  always_comb begin
    ready      = state_q == IDLE;
    load_x     = state_q == LOAD_X;
    load_y     = state_q == LOAD_Y;
    x_en       = load_x & ld_ok;
    y_en       = load_y & ld_ok;
    iter_en    = state_q == PROC;
    iter_idx   = iter_q;
    iter_first = iter_en & (iter_q == '0);
    iter_last  = iter_en & (iter_q == last_idx);
    shift      = iter_en & (op_q == DIV) & ~iter_last;
    done       = state_q == DONE;
    error      = state_q == ERR;
    err_code   = err_q;
  end
endmodule

// File: tb/tb_mdr_sequencer.sv
// tb_mdr_sequencer: directed scenarios for the MDR control sequencer.
module tb_mdr_sequencer;
  localparam int DW = 16;
  localparam int CW = 5;
  logic          clk = 1'b0, rst = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          start = 1'b0, load = 1'b0, dp_ovf = 1'b0, abort = 1'b0, res_ack = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready, load_x, load_y, x_en, y_en, iter_en, iter_first, iter_last, shift, done, error;
  logic [1:0]    op_q, err_code;
  logic [CW-1:0] iter_idx;
  int            tests = 0, fails = 0;

  mdr_sequencer #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .op(op), .start(start), .load(load), .data_in(data_in),
    .dp_ovf(dp_ovf), .abort(abort), .res_ack(res_ack), .ready(ready), .load_x(load_x),
    .load_y(load_y), .x_en(x_en), .y_en(y_en), .op_q(op_q), .iter_en(iter_en),
    .iter_first(iter_first), .iter_last(iter_last), .iter_idx(iter_idx), .shift(shift),
    .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({ready, load_x, load_y, x_en, y_en, iter_en, iter_first, iter_last, shift, done, error, op_q, err_code, iter_idx} !== {1'b1, 19'b0}) begin
      fails++;
      $display("FAIL reset_values got %b exp %b", {ready, load_x, load_y, x_en, y_en, iter_en, iter_first, iter_last, shift, done, error, op_q, err_code, iter_idx}, {1'b1, 19'b0});
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    start = 1'b1; op = 2'b00;
    tick();
    start = 1'b0; #1;
    tests++;
    if ({load_x, x_en, ready, op_q} !== 5'b10000) begin fails++; $display("FAIL mult_loadx got %b exp %b", {load_x, x_en, ready, op_q}, 5'b10000); end
    tick();
    load = 1'b1; data_in = 16'd3; #1;
    tests++;
    if (x_en !== 1'b1) begin fails++; $display("FAIL mult_x_en got %b exp 1", x_en); end
    tick();
    load = 1'b0; #1;
    tests++;
    if ({load_y, y_en, load_x} !== 3'b100) begin fails++; $display("FAIL mult_loady got %b exp 100", {load_y, y_en, load_x}); end
    tick();
    load = 1'b1; data_in = 16'hFFFB; #1;
    tests++;
    if (y_en !== 1'b1) begin fails++; $display("FAIL mult_y_en got %b exp 1", y_en); end
    for (int i = 0; i < 16; i++) begin
      tick();
      load = 1'b0; #1;
      tests++;
      if ({iter_en, iter_first, iter_last, shift, done, iter_idx} !== {1'b1, i == 0, i == 15, 2'b00, 5'(i)}) begin
        fails++;
        $display("FAIL mult_iter%0d got %b exp %b", i, {iter_en, iter_first, iter_last, shift, done, iter_idx}, {1'b1, i == 0, i == 15, 2'b00, 5'(i)});
      end
    end
    tick(); #1;
    tests++;
    if ({done, iter_en, error, ready} !== 4'b1000) begin fails++; $display("FAIL mult_done got %b exp 1000", {done, iter_en, error, ready}); end
    tick(); #1;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL mult_done_held got %b exp 1", done); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0; #1;
    tests++;
    if ({ready, done} !== 2'b10) begin fails++; $display("FAIL mult_ack got %b exp 10", {ready, done}); end
  endtask

  task automatic test_div0();
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd100;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd0; #1;
    tests++;
    if (y_en !== 1'b1) begin fails++; $display("FAIL div0_y_en got %b exp 1", y_en); end
    tick();
    load = 1'b0; #1;
    tests++;
    if ({error, err_code, iter_en, done} !== 5'b10100) begin fails++; $display("FAIL div0_err got %b exp 10100", {error, err_code, iter_en, done}); end
    tick(); tick(); #1;
    tests++;
    if ({error, err_code, iter_en} !== 4'b1010) begin fails++; $display("FAIL div0_held got %b exp 1010", {error, err_code, iter_en}); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0; #1;
    tests++;
    if ({ready, error, err_code} !== 4'b1000) begin fails++; $display("FAIL div0_ack got %b exp 1000", {ready, error, err_code}); end
  endtask

  task automatic test_sqrt();
    start = 1'b1; op = 2'b10;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; data_in = 16'hFFFC; #1;
    tests++;
    if (x_en !== 1'b1) begin fails++; $display("FAIL sqneg_x_en got %b exp 1", x_en); end
    tick();
    load = 1'b0; #1;
    tests++;
    if ({error, err_code, load_y} !== 4'b1100) begin fails++; $display("FAIL sqneg_err got %b exp 1100", {error, err_code, load_y}); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    start = 1'b1; op = 2'b10;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd49; #1;
    tests++;
    if (x_en !== 1'b1) begin fails++; $display("FAIL sqrt_x_en got %b exp 1", x_en); end
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0; #1;
      tests++;
      if ({iter_en, iter_first, iter_last, shift, load_y, iter_idx} !== {1'b1, i == 0, i == 7, 2'b00, 5'(i)}) begin
        fails++;
        $display("FAIL sqrt_iter%0d got %b exp %b", i, {iter_en, iter_first, iter_last, shift, load_y, iter_idx}, {1'b1, i == 0, i == 7, 2'b00, 5'(i)});
      end
    end
    tick(); #1;
    tests++;
    if ({done, iter_en, error} !== 3'b100) begin fails++; $display("FAIL sqrt_done got %b exp 100", {done, iter_en, error}); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic test_held_load_ovf();
    start = 1'b1; op = 2'b00;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd2; #1;
    tests++;
    if (x_en !== 1'b1) begin fails++; $display("FAIL held_x_en got %b exp 1", x_en); end
    tick(); #1;
    tests++;
    if ({load_y, y_en} !== 2'b10) begin fails++; $display("FAIL held_no_y1 got %b exp 10", {load_y, y_en}); end
    tick(); #1;
    tests++;
    if ({load_y, y_en} !== 2'b10) begin fails++; $display("FAIL held_no_y2 got %b exp 10", {load_y, y_en}); end
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd7; #1;
    tests++;
    if (y_en !== 1'b1) begin fails++; $display("FAIL held_y_en got %b exp 1", y_en); end
    for (int i = 0; i < 16; i++) begin
      tick();
      load = 1'b0;
      dp_ovf = (i >= 14);
    end
    #1;
    tests++;
    if ({iter_last, iter_idx} !== {1'b1, 5'd15}) begin fails++; $display("FAIL ovf_last got %b exp %b", {iter_last, iter_idx}, {1'b1, 5'd15}); end
    tick();
    dp_ovf = 1'b0; #1;
    tests++;
    if ({error, err_code, done} !== 4'b1110) begin fails++; $display("FAIL ovf_err got %b exp 1110", {error, err_code, done}); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd100;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd7;
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 1'b0; #1;
      tests++;
      if ({iter_en, shift, iter_idx} !== {2'b11, 5'(i)}) begin fails++; $display("FAIL abort_iter%0d got %b exp %b", i, {iter_en, shift, iter_idx}, {2'b11, 5'(i)}); end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; #1;
    tests++;
    if ({ready, iter_en, done, err_code, iter_idx} !== {1'b1, 9'b0}) begin fails++; $display("FAIL abort_proc got %b exp %b", {ready, iter_en, done, err_code, iter_idx}, {1'b1, 9'b0}); end
    start = 1'b1; op = 2'b00;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; abort = 1'b1; #1;
    tests++;
    if (x_en !== 1'b0) begin fails++; $display("FAIL abort_strobe got %b exp 0", x_en); end
    tick();
    load = 1'b0; abort = 1'b0; #1;
    tests++;
    if ({ready, load_x} !== 2'b10) begin fails++; $display("FAIL abort_loadx got %b exp 10", {ready, load_x}); end
    start = 1'b1; op = 2'b11;
    tick();
    start = 1'b0; #1;
    tests++;
    if ({error, err_code, op_q} !== 5'b11111) begin fails++; $display("FAIL illegal_op got %b exp 11111", {error, err_code, op_q}); end
    abort = 1'b1;
    tick();
    abort = 1'b0; #1;
    tests++;
    if ({ready, error, err_code} !== 4'b1000) begin fails++; $display("FAIL abort_err got %b exp 1000", {ready, error, err_code}); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd50;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; data_in = 16'd7;
    for (int i = 0; i < 16; i++) begin
      tick();
      load = 1'b0; #1;
      if (i >= 14) begin
        tests++;
        if ({shift, iter_last} !== {i == 14, i == 15}) begin fails++; $display("FAIL div_shift%0d got %b exp %b", i, {shift, iter_last}, {i == 14, i == 15}); end
      end
    end
    tick(); #1;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_done got %b exp 1", done); end
    res_ack = 1'b1; start = 1'b1; op = 2'b10;
    tick();
    res_ack = 1'b0; start = 1'b0; #1;
    tests++;
    if ({load_x, ready, done, op_q} !== 5'b10010) begin fails++; $display("FAIL b2b_loadx got %b exp 10010", {load_x, ready, done, op_q}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = 2'b00;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({ready, load_x, load_y, x_en, y_en, iter_en, iter_first, iter_last, shift, done, error, op_q, err_code, iter_idx} !== {1'b1, 19'b0}) begin
      fails++;
      $display("FAIL async_reset got %b exp %b", {ready, load_x, load_y, x_en, y_en, iter_en, iter_first, iter_last, shift, done, error, op_q, err_code, iter_idx}, {1'b1, 19'b0});
    end
    #2 rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div0();
    test_sqrt();
    test_held_load_ovf();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdr_sequencer.md
# mdr_sequencer

Parametrised control sequencer for the multiply/divide/square-root (MDR) unit. It accepts an operation code, steps operand loading with edge-detected load strobes and runs an internal iteration counter sized by operation and width. It classifies errors into codes and holds the result until it is acknowledged, and it supports abort and back-to-back operations. It sits between the host-side start/load/ack signals and the MDR datapath, whose registers and ALU it enables.

## Interface
- DW, 16: operand width; must be even and ≥ 4
- ITER_MD, DW: iteration count for MULT and DIV
- ITER_SQ, DW/2: iteration count for SQRT
- CW, $clog2(DW+1): iteration counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  2  00 MULT, 01 DIV, 10 SQRT, 11 illegal; sampled only with start in IDLE/DONE
- start  in  1  begins an operation
- load  in  1  operand-present level; its rising edge loads one operand
- data_in  in  DW  operand bus, two's complement
- dp_ovf  in  1  datapath multiply-overflow flag, sampled on the last MULT iteration
- abort  in  1  synchronous abort
- res_ack  in  1  host consumes the result or error
- ready  out  1  IDLE indicator
- load_x / load_y  out  1  requests operand X / Y
- x_en / y_en  out  1  one-cycle operand register strobes
- op_q  out  2  latched operation code
- iter_en  out  1  datapath iteration enable
- iter_first / iter_last  out  1  first / last iteration markers
- iter_idx  out  CW  current iteration index
- shift  out  1  A,Q left-shift enable (DIV only)
- done  out  1  result valid, held until res_ack
- error  out  1  error valid, held until res_ack
- err_code  out  2  00 none, 01 DIV0, 10 SQRT_NEG, 11 MULT_OVF or illegal op

## Operation
- **States:** IDLE, LOAD_X, LOAD_Y, PROC, DONE, ERR.
- **Rising-edge detect:** `ld_rise = load & ~load_d`, where load_d is registered. This prevents one held load from filling both X and Y.
- **IDLE:** ready=1.
  - start=1 latches op into op_q.
  - op=11 → ERR with err_code=11.
  - Any other op → LOAD_X.
- **LOAD_X:** load_x=1.
  - On ld_rise with start=0, assert x_en for that cycle and register x_neg=data_in[DW-1].
  - For SQRT: if x_neg=1 → ERR with code 10; otherwise → PROC.
  - For other ops → LOAD_Y.
- **LOAD_Y:** load_y=1.
  - On ld_rise with start=0, assert y_en.
  - DIV with data_in==0 → ERR with code 01.
  - Otherwise → PROC.
- **PROC:** iter_en=1.
  - iter_idx counts from 0 to N-1, where N=ITER_SQ for SQRT and ITER_MD otherwise.
  - iter_first=(iter_idx==0); iter_last=(iter_idx==N-1).
  - shift=iter_en & (op_q==DIV) & ~iter_last.
  - At iter_last: MULT with dp_ovf=1 → ERR with code 11; otherwise → DONE.
- **DONE:** done=1.
  - res_ack=1 → IDLE.
  - res_ack=1 together with start=1 → LOAD_X directly, latching the new op (back-to-back). An illegal op in this case → ERR.
- **ERR:** error=1; err_code is held stable. res_ack=1 → IDLE and err_code clears to 00.
- **abort=1:** in any state other than IDLE, goes to IDLE next cycle, clears err_code and iter_idx, and asserts no strobes that cycle. abort has priority over every other transition.
- **Ignored inputs:** start outside IDLE/DONE is ignored; ld_rise outside LOAD_X/LOAD_Y is ignored.

## Timing
- **Reset:** state=IDLE, ready=1. All other outputs are 0: load_x, load_y, x_en, y_en, iter_en, iter_first, iter_last, shift, done, error. Also op_q=00, err_code=00, iter_idx=0, load_d=0, x_neg=0.
- **Output decode:** all outputs are Moore, decoded from registered state/counter, except x_en and y_en, which are combinational from ld_rise in the load states.
- **Latency:** y_en at cycle t (or x_en for SQRT) → PROC occupies cycles t+1 … t+N → done=1 from cycle t+N+1.
- **Error latency:** operand-error detection flags error at t+1. MULT overflow flags error at t+N+1.
- **Clean entry:** iter_idx is reset to 0 on every PROC entry, so no stale count carries over.
- **Load timing:** ld_rise arriving in the same cycle the FSM enters LOAD_X is not serviced. The load must rise while the FSM is in LOAD_X.
- **Asynchronous reset mid-PROC:** returns to IDLE immediately with the reset values above.

## Test plan
- **MULT, DW=16:**
  - Stimulus: start, op=00; load pulses with X=3 then Y=-5; dp_ovf=0.
  - Required response: x_en, then y_en; iter_en for 16 cycles; iter_first on idx 0, iter_last on idx 15; done at t+17; shift never set; res_ack → ready=1.
- **DIV by zero:**
  - Stimulus: op=01, X=100, Y=0.
  - Required response: error=1 and err_code=01 one cycle after y_en; iter_en never asserted; held until res_ack.
- **SQRT:**
  - X=-4: err_code=10 immediately after x_en; load_y never asserted.
  - X=49: PROC for exactly 8 cycles, then done.
- **Held load and MULT overflow:**
  - Held load: load kept at 1 across LOAD_X→LOAD_Y yields x_en only; y_en fires only after load drops and rises again.
  - MULT overflow: dp_ovf=1 at iter_last gives err_code=11.
- **Abort:** abort at iter_idx=5 of a DIV → IDLE next cycle, iter_idx=0, err_code=00, done=0.
- **Back-to-back:** in DONE, res_ack=1 with start=1 and op=10 → next state LOAD_X with op_q=10, ready stays 0.
